// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-port byte memory.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int          MEM_SIZE     = 4096,
    parameter int          STARVE_LIMIT = 4,
    parameter logic [31:0] BAD_VAL      = 32'hBAD0_BAD0
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    output logic        if_resp_err,

    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [3:0]  d_byte_en,
    input  logic [31:0] d_wdata,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_rdata,
    output logic        d_resp_err,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read_req,
    output logic        mem_write_req,
    output logic [3:0]  mem_byte_en,
    input  logic [31:0] mem_rdata_raw
);

    localparam int              CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [31:0]     MAX_ADDR = 32'(MEM_SIZE - 4);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;

    logic        cap_fetch;
    logic [31:0] cap_addr;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata;
    logic [31:0] rsp_data;

    logic grant_f, grant_d, grant_err;
    logic f_err, d_err;
    logic in_idle, in_access;

    // Fetch wins only when data is absent or fetch has waited STARVE_LIMIT data grants.
    assign grant_f   = if_req_valid && (!d_req_valid || (starve_cnt == CNT_MAX));
    assign grant_d   = d_req_valid && !grant_f;
    assign f_err     = (if_addr[1:0] != 2'b00) || (if_addr > MAX_ADDR);
    assign d_err     = (d_addr > MAX_ADDR) || (d_byte_en == 4'b0000);
    assign grant_err = grant_f ? f_err : d_err;

    assign in_idle      = (state == IDLE) && !rst;
    assign if_req_ready = in_idle && grant_f;
    assign d_req_ready  = in_idle && grant_d;

    // Strobes are gated by rst so a write interrupted in ACCESS never lands.
    assign in_access     = (state == ACCESS) && !rst;
    assign mem_addr      = in_access ? cap_addr  : 32'd0;
    assign mem_wdata     = in_access ? cap_wdata : 32'd0;
    assign mem_byte_en   = in_access ? cap_be    : 4'd0;
    assign mem_read_req  = in_access && !cap_we;
    assign mem_write_req = in_access && cap_we;

    assign if_resp_data = rsp_data;
    assign d_resp_rdata = rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            cap_fetch     <= 1'b0;
            cap_addr      <= 32'd0;
            cap_we        <= 1'b0;
            cap_be        <= 4'd0;
            cap_wdata     <= 32'd0;
            rsp_data      <= 32'd0;
            if_resp_valid <= 1'b0;
            if_resp_err   <= 1'b0;
            d_resp_valid  <= 1'b0;
            d_resp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_f || grant_d) begin
                        cap_fetch <= grant_f;
                        cap_addr  <= grant_f ? if_addr : d_addr;
                        cap_we    <= grant_d && d_we;
                        cap_be    <= grant_f ? 4'hF : d_byte_en;
                        cap_wdata <= grant_f ? 32'd0 : d_wdata;

                        if (grant_f)
                            starve_cnt <= '0;
                        else if (if_req_valid)
                            starve_cnt <= (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
                        else
                            starve_cnt <= '0;

                        if (grant_err) begin
                            rsp_data      <= BAD_VAL;
                            if_resp_valid <= grant_f;
                            if_resp_err   <= grant_f;
                            d_resp_valid  <= grant_d;
                            d_resp_err    <= grant_d;
                            state         <= RESP;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    rsp_data      <= cap_we ? BAD_VAL : mem_rdata_raw;
                    if_resp_valid <= cap_fetch;
                    if_resp_err   <= 1'b0;
                    d_resp_valid  <= !cap_fetch;
                    d_resp_err    <= 1'b0;
                    state         <= RESP;
                end
                RESP: begin
                    if_resp_valid <= 1'b0;
                    if_resp_err   <= 1'b0;
                    d_resp_valid  <= 1'b0;
                    d_resp_err    <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
